pipe_hazard_ctrl: RTL

Central stall/flush controller for the five-stage pipeline. It drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers from four sources: outstanding memory transactions, multi-cycle execute operations, load-use hazards and EX-stage redirects. A small state machine discards an in-flight instruction fetch that a redirect has made stale. A stall-cycle counter is provided for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline stall/flush controller with stale-fetch drop FSM and stall counter
module pipe_hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_busy,
    input  logic             d_busy,
    input  logic             ex_mdu_busy,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_redirect,
    output logic             stall_if,
    output logic             stall_id,
    output logic             stall_ex,
    output logic             stall_mem,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             flush_wb,
    output logic             redirect_ack,
    output logic             drop_fetch,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DROP = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic       load_use;

    assign load_use = ex_valid && ex_is_load && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        stall_ex     = 1'b0;
        stall_mem    = 1'b0;
        flush_id     = 1'b0;
        flush_ex     = 1'b0;
        flush_mem    = 1'b0;
        flush_wb     = 1'b0;
        redirect_ack = 1'b0;
        if (reset) begin
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            flush_mem = 1'b1;
            flush_wb  = 1'b1;
        end else if (d_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            flush_wb  = 1'b1;
        end else if (ex_mdu_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            flush_mem = 1'b1;
        end else if (ex_redirect) begin
            // ID is flushed here, so a coincident load-use hazard needs no stall
            flush_id     = 1'b1;
            flush_ex     = 1'b1;
            redirect_ack = 1'b1;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end else if (i_busy || (state == ST_DROP)) begin
            stall_if = 1'b1;
            flush_id = 1'b1;
        end
    end

    assign drop_fetch = !reset && (state == ST_DROP) && !i_busy;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (redirect_ack && i_busy) state_next = ST_DROP;
            // only one fetch can be outstanding, so one dropped response clears DROP
            ST_DROP: if (!i_busy) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            stall_cycles <= '0;
        end else begin
            state <= state_next;
            if (stall_if && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
